// File: rtl/otter_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the multicycle OTTER core.
// One bit per cycle in CALC (shift-add multiply / restoring divide on
// operand magnitudes), sign fix-up and result select in FIX, DONE in FIN.
// Fixed latency of XLEN+2 cycles for every operation.
module otter_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        FIN  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                signA_q, signA_d;
    logic                signB_q, signB_d;
    logic                divZero_q, divZero_d;
    logic [XLEN-1:0]     srcA_q, srcA_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                inSignA, inSignB;
    logic [XLEN-1:0]     magA, magB;
    logic [XLEN:0]       mulSum;
    logic [XLEN:0]       divShift, divTrial;
    logic                divOk;
    logic [XLEN-1:0]     divRemNext;
    logic [2*XLEN-1:0]   prodFix;
    logic [XLEN-1:0]     quoFix, remFix;

    // Operand signs and magnitudes at accept time, one multiply/divide step, and the FIX-stage sign correction
    always_comb begin
        inSignA    = src_a_i[XLEN-1] & ((funct3_i == 3'b001) | (funct3_i == 3'b010) |
                                        (funct3_i == 3'b100) | (funct3_i == 3'b110));
        inSignB    = src_b_i[XLEN-1] & ((funct3_i == 3'b001) | (funct3_i == 3'b100) |
                                        (funct3_i == 3'b110));
        magA       = inSignA ? (-src_a_i) : src_a_i;
        magB       = inSignB ? (-src_b_i) : src_b_i;
        mulSum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
        divShift   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        divTrial   = divShift - {1'b0, opnd_q};
        divOk      = ~divTrial[XLEN];
        divRemNext = divOk ? divTrial[XLEN-1:0] : divShift[XLEN-1:0];
        prodFix    = (signA_q ^ signB_q) ? (-acc_q) : acc_q;
        quoFix     = (signA_q ^ signB_q) ? (-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        remFix     = signA_q ? (-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    end

    // Next-state logic for the control FSM and the datapath registers it steers
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        signA_d   = signA_q;
        signB_d   = signB_q;
        divZero_d = divZero_q;
        srcA_d    = srcA_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        result_d  = result_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d      = funct3_i;
                    signA_d   = inSignA;
                    signB_d   = inSignB;
                    divZero_d = (src_b_i == {XLEN{1'b0}});
                    srcA_d    = src_a_i;
                    cnt_d     = '0;
                    if (funct3_i[2]) begin
                        opnd_d = magB;
                        acc_d  = {{XLEN{1'b0}}, magA};
                    end else begin
                        opnd_d = magA;
                        acc_d  = {{XLEN{1'b0}}, magB};
                    end
                    state_d = CALC;
                end
            end
            CALC: begin
                if (op_q[2]) begin
                    acc_d = {divRemNext, acc_q[XLEN-2:0], divOk};
                end else begin
                    acc_d = {mulSum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                unique case (op_q)
                    3'b000:                 result_d = prodFix[XLEN-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prodFix[2*XLEN-1:XLEN];
                    3'b100, 3'b101:         result_d = divZero_q ? {XLEN{1'b1}} : quoFix;
                    default:                result_d = divZero_q ? srcA_q : remFix;
                endcase
                state_d = FIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            signA_q   <= 1'b0;
            signB_q   <= 1'b0;
            divZero_q <= 1'b0;
            srcA_q    <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            signA_q   <= signA_d;
            signB_q   <= signB_d;
            divZero_q <= divZero_d;
            srcA_q    <= srcA_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == FIN);
    assign result_o = result_q;

endmodule

// File: tb/tb_otter_muldiv_unit.sv
// Self-checking bench for otter_muldiv_unit: directed RV32M vectors,
// randomized operations against an arithmetic reference model, START
// filtering, back-to-back issue and mid-operation reset.
module tb_otter_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int passes = 0;

    otter_muldiv_unit #(.XLEN(32)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .funct3_i (funct3),
        .src_a_i  (srcA),
        .src_b_i  (srcB),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M semantics computed with plain wide arithmetic
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, sp;
        logic [63:0]        up;
        int                 a32, b32;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'b0, b};
        a32 = a;
        b32 = b;
        case (f)
            3'b000: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            3'b001: begin sp = sa * sb; return sp[63:32]; end
            3'b010: begin sp = sa * ub; return sp[63:32]; end
            3'b011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'b100: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return a32 / b32;
            end
            3'b101: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return a32 % b32;
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Wait for IDLE, issue one op, scramble inputs after acceptance, and wait (bounded) for DONE
    task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int cycles, output bit busyOk);
        int guard = 0;
        while (busy !== 1'b0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b1; funct3 = f; srcA = a; srcB = b;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); srcA = $urandom; srcB = $urandom;
        cycles = 1;
        busyOk = (busy === 1'b1);
        while (done !== 1'b1 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            busyOk = busyOk & (busy === 1'b1);
        end
        res = result;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; funct3 = 3'b0; srcA = 32'h0; srcB = 32'h0;
        #3;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b expected 0", busy); else passes++;
        checks++;
        if (done !== 1'b0) $display("[TB] FAIL reset_done got %b expected 0", done); else passes++;
        checks++;
        if (result !== 32'h0) $display("[TB] FAIL reset_result got %h expected 00000000", result); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL idle_busy got %b expected 0", busy); else passes++;
    endtask

    task automatic test_directed();
        logic [2:0]  fv [12] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110,
                                 3'b101, 3'b111, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] av [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd2, 32'd2, 32'd7, 32'd7,
                                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        logic [31:0] res;
        int          cycles;
        bit          busyOk;
        for (int i = 0; i < 12; i++) begin
            runOp(fv[i], av[i], bv[i], res, cycles, busyOk);
            checks++;
            if (res !== ev[i]) $display("[TB] FAIL directed_%0d_result got %h expected %h", i, res, ev[i]); else passes++;
            checks++;
            if (cycles != 34) $display("[TB] FAIL directed_%0d_latency got %0d expected 34", i, cycles); else passes++;
            checks++;
            if (!busyOk) $display("[TB] FAIL directed_%0d_busy got low within cycles 1..34 expected high", i); else passes++;
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, exp, res;
        int          cycles;
        bit          busyOk;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            case ($urandom_range(0, 5))
                0: a = 32'h0;
                1: a = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            exp = refModel(f, a, b);
            runOp(f, a, b, res, cycles, busyOk);
            checks++;
            if (res !== exp || cycles != 34)
                $display("[TB] FAIL random_%0d op=%0d a=%h b=%h got %h after %0d cycles expected %h after 34",
                         i, f, a, b, res, cycles, exp);
            else passes++;
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] exp;
        int          cycles;
        int          guard = 0;
        exp = refModel(3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
        while (busy !== 1'b0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b1; funct3 = 3'b011; srcA = 32'h1234_5678; srcB = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < 100) begin
            if (cycles == 5) begin
                start = 1'b1; funct3 = 3'b100; srcA = 32'd99; srcB = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        checks++;
        if (result !== exp) $display("[TB] FAIL restart_ignored_result got %h expected %h", result, exp); else passes++;
        checks++;
        if (cycles != 34) $display("[TB] FAIL restart_ignored_latency got %0d expected 34", cycles); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res1, res2, exp1, exp2;
        int          cycles;
        bit          busyOk;
        exp1 = refModel(3'b001, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        exp2 = refModel(3'b111, 32'hCAFE_0001, 32'h0000_1003);
        runOp(3'b001, 32'hDEAD_BEEF, 32'h0BAD_F00D, res1, cycles, busyOk);
        checks++;
        if (res1 !== exp1) $display("[TB] FAIL b2b_first_result got %h expected %h", res1, exp1); else passes++;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL b2b_busy_after_done got %b expected 0", busy); else passes++;
        checks++;
        if (done !== 1'b0) $display("[TB] FAIL b2b_done_width got %b expected 0", done); else passes++;
        checks++;
        if (result !== exp1) $display("[TB] FAIL b2b_result_held got %h expected %h", result, exp1); else passes++;
        runOp(3'b111, 32'hCAFE_0001, 32'h0000_1003, res2, cycles, busyOk);
        checks++;
        if (res2 !== exp2) $display("[TB] FAIL b2b_second_result got %h expected %h", res2, exp2); else passes++;
        checks++;
        if (cycles != 34) $display("[TB] FAIL b2b_second_latency got %0d expected 34", cycles); else passes++;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res, exp;
        int          cycles;
        bit          busyOk;
        bit          sawDone = 1'b0;
        int          guard = 0;
        while (busy !== 1'b0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b1; funct3 = 3'b100; srcA = 32'h7654_3210; srcB = 32'd13;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL midreset_busy got %b expected 0", busy); else passes++;
        checks++;
        if (result !== 32'h0) $display("[TB] FAIL midreset_result got %h expected 00000000", result); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) sawDone = 1'b1;
        end
        checks++;
        if (sawDone) $display("[TB] FAIL midreset_no_done got a DONE pulse expected none"); else passes++;
        exp = refModel(3'b110, 32'hFFFF_FF00, 32'd7);
        runOp(3'b110, 32'hFFFF_FF00, 32'd7, res, cycles, busyOk);
        checks++;
        if (res !== exp || cycles != 34)
            $display("[TB] FAIL midreset_fresh_op got %h after %0d cycles expected %h after 34", res, cycles, exp);
        else passes++;
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
